// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the 2:1 Wishbone arbiter
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Counter must hold TIMEOUT_CYCLES-1; never narrower than one bit.
  function automatic int wd_width(input int timeout_cycles);
    return (timeout_cycles <= 2) ? 1 : $clog2(timeout_cycles);
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - stalled-strobe counter that fires after TIMEOUT_CYCLES waits
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = wd_width(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_fire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_fire = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || o_fire) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter_2to1.sv
// rtl/wb_arbiter_2to1.sv - round-robin 2:1 Wishbone arbiter with per-strobe watchdog
module wb_arbiter_2to1
  import wb_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cyc_i_0,
  input  logic                  stb_i_0,
  input  logic                  we_i_0,
  input  logic [ADDR_WIDTH-1:0] adr_i_0,
  input  logic [DATA_WIDTH-1:0] dat_i_0,
  output logic [DATA_WIDTH-1:0] dat_o_0,
  output logic                  ack_o_0,
  input  logic                  cyc_i_1,
  input  logic                  stb_i_1,
  input  logic                  we_i_1,
  input  logic [ADDR_WIDTH-1:0] adr_i_1,
  input  logic [DATA_WIDTH-1:0] dat_i_1,
  output logic [DATA_WIDTH-1:0] dat_o_1,
  output logic                  ack_o_1,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  input  logic                  ack_i,
  output logic [1:0]            gnt_o,
  output logic                  timeout_o
);

  arb_state_t r_state;
  logic [1:0] r_gnt;
  logic       r_last;

  logic w_sel0, w_sel1, w_cyc, w_stb, w_fire, w_wd_en;

  assign w_sel0 = (r_state == GNT0);
  assign w_sel1 = (r_state == GNT1);

  // Strobe is qualified by cyc so a mid-transfer cyc drop kills stb_o at once.
  assign w_cyc = (w_sel0 & cyc_i_0) | (w_sel1 & cyc_i_1);
  assign w_stb = w_cyc & ((w_sel0 & stb_i_0) | (w_sel1 & stb_i_1));

  assign w_wd_en = w_stb & ~ack_i;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (~w_wd_en),
    .i_en  (w_wd_en),
    .o_fire(w_fire)
  );

  assign cyc_o     = w_cyc;
  assign stb_o     = w_stb & ~w_fire;
  assign we_o      = (w_sel0 & we_i_0) | (w_sel1 & we_i_1);
  assign adr_o     = w_sel0 ? adr_i_0 : (w_sel1 ? adr_i_1 : '0);
  assign dat_o     = w_sel0 ? dat_i_0 : (w_sel1 ? dat_i_1 : '0);
  assign dat_o_0   = dat_i;
  assign dat_o_1   = dat_i;
  assign ack_o_0   = w_sel0 & (ack_i | w_fire);
  assign ack_o_1   = w_sel1 & (ack_i | w_fire);
  assign timeout_o = w_fire;
  assign gnt_o     = r_gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_gnt   <= GNT_NONE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (cyc_i_0 && (!cyc_i_1 || r_last)) begin
            r_state <= GNT0;
            r_gnt   <= GNT_M0;
          end else if (cyc_i_1) begin
            r_state <= GNT1;
            r_gnt   <= GNT_M1;
          end
        end
        GNT0: begin
          if (!cyc_i_0) begin
            r_state <= IDLE;
            r_gnt   <= GNT_NONE;
            r_last  <= 1'b0;
          end
        end
        GNT1: begin
          if (!cyc_i_1) begin
            r_state <= IDLE;
            r_gnt   <= GNT_NONE;
            r_last  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= GNT_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// tb/tb_wb_arbiter_2to1.sv - scoreboard bench for wb_arbiter_2to1
module tb_wb_arbiter_2to1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_i_0, stb_i_0, we_i_0, ack_o_0;
  logic [31:0] adr_i_0, dat_i_0, dat_o_0;
  logic        cyc_i_1, stb_i_1, we_i_1, ack_o_1;
  logic [31:0] adr_i_1, dat_i_1, dat_o_1;
  logic        cyc_o, stb_o, we_o, ack_i, timeout_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [1:0]  gnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0]  ack;
    logic [31:0] dat;
    logic        to;
    logic        stb;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  wb_arbiter_2to1 #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cyc_i_0(cyc_i_0), .stb_i_0(stb_i_0), .we_i_0(we_i_0), .adr_i_0(adr_i_0),
    .dat_i_0(dat_i_0), .dat_o_0(dat_o_0), .ack_o_0(ack_o_0),
    .cyc_i_1(cyc_i_1), .stb_i_1(stb_i_1), .we_i_1(we_i_1), .adr_i_1(adr_i_1),
    .dat_i_1(dat_i_1), .dat_o_1(dat_o_1), .ack_o_1(ack_o_1),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack_i), .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] a, input logic to, input logic stb);
    exp_t e;
    e.ack = a;
    e.dat = dat_i;
    e.to  = to;
    e.stb = stb;
    q.push_back(e);
  endtask

  // Monitor: every ack the DUT presents must match the next expected response.
  always @(negedge clk) begin
    if (rst === 1'b1 && (ack_o_0 === 1'b1 || ack_o_1 === 1'b1)) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: got ack=%b with empty scoreboard", {ack_o_1, ack_o_0});
      end else begin
        exp_t e;
        logic [31:0] d;
        e = q.pop_front();
        d = ack_o_0 ? dat_o_0 : dat_o_1;
        if ({ack_o_1, ack_o_0} !== e.ack || d !== e.dat || timeout_o !== e.to || stb_o !== e.stb) begin
          n_fail++;
          $display("FAIL ack_resp: got ack=%b dat=0x%0h to=%b stb=%b expected ack=%b dat=0x%0h to=%b stb=%b",
                   {ack_o_1, ack_o_0}, d, timeout_o, stb_o, e.ack, e.dat, e.to, e.stb);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    {cyc_i_0, stb_i_0, we_i_0, cyc_i_1, stb_i_1, we_i_1, ack_i} = '0;
    adr_i_0 = '0; dat_i_0 = '0; adr_i_1 = '0; dat_i_1 = '0; dat_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_slave", {27'h0, cyc_o, stb_o, we_o, ack_o_0, ack_o_1}, 32'h0);
    chk("rst_adr", adr_o, 32'h0);
    chk("rst_timeout", 32'(timeout_o), 32'h0);
    rst = 1'b1;

    // Single master write
    tick; cyc_i_0 = 1; stb_i_0 = 1; we_i_0 = 1; adr_i_0 = 32'h10; dat_i_0 = 32'hA5A5A5A5;
    @(negedge clk); chk("single_latency_gnt", 32'(gnt_o), 32'h0);
    tick;
    @(negedge clk); chk("single_gnt", 32'(gnt_o), 32'h1);
    chk("single_adr", adr_o, 32'h10);
    chk("single_dat", dat_o, 32'hA5A5A5A5);
    chk("single_we_stb", {30'h0, we_o, stb_o}, 32'h3);
    tick; ack_i = 1; dat_i = 32'h0BAD0001; push(2'b01, 0, 1);
    @(negedge clk);
    tick; ack_i = 0; cyc_i_0 = 0; stb_i_0 = 0;
    @(negedge clk); chk("drop_cyc_o", {30'h0, cyc_o, stb_o}, 32'h0);
    tick;
    @(negedge clk); chk("release_gnt", 32'(gnt_o), 32'h0);

    // Master 1 read
    tick; cyc_i_1 = 1; stb_i_1 = 1; we_i_1 = 0; adr_i_1 = 32'h20;
    tick;
    @(negedge clk); chk("read_gnt", 32'(gnt_o), 32'h2);
    chk("read_we", 32'(we_o), 32'h0);
    tick; ack_i = 1; dat_i = 32'h12345678; push(2'b10, 0, 1);
    @(negedge clk); chk("read_dat_o_1", dat_o_1, 32'h12345678);
    chk("read_dat_o_0", dat_o_0, 32'h12345678);
    tick; ack_i = 0; cyc_i_1 = 0; stb_i_1 = 0;
    tick;

    // Round-robin with both masters requesting continuously
    adr_i_0 = 32'h100; adr_i_1 = 32'h200;
    for (int r = 0; r < 4; r++) begin
      int m;
      m = r & 1;
      if (r == 0) begin
        cyc_i_0 = 1; stb_i_0 = 1; cyc_i_1 = 1; stb_i_1 = 1;
      end else if (m == 1) begin
        cyc_i_0 = 1; stb_i_0 = 1;
      end else begin
        cyc_i_1 = 1; stb_i_1 = 1;
      end
      @(negedge clk); chk($sformatf("rr%0d_gap", r), 32'(gnt_o), 32'h0);
      for (int k = 0; k < 2; k++) begin
        tick; ack_i = 1; dat_i = 32'hC000_0000 + 32'(r * 2 + k);
        push((m == 0) ? 2'b01 : 2'b10, 0, 1);
        @(negedge clk); chk($sformatf("rr%0d_gnt%0d", r, k), 32'(gnt_o), (m == 0) ? 32'h1 : 32'h2);
        if (k == 0) chk($sformatf("rr%0d_adr", r), adr_o, (m == 0) ? 32'h100 : 32'h200);
      end
      tick; ack_i = 0;
      if (m == 0) begin cyc_i_0 = 0; stb_i_0 = 0; end
      else begin cyc_i_1 = 0; stb_i_1 = 0; end
      @(negedge clk); chk($sformatf("rr%0d_hold", r), 32'(gnt_o), (m == 0) ? 32'h1 : 32'h2);
      tick;
    end
    cyc_i_0 = 0; stb_i_0 = 0;
    tick;

    // Watchdog fires on the 4th stalled strobe; ack on that cycle suppresses it
    cyc_i_0 = 1; stb_i_0 = 1; dat_i = 32'hDEAD0000;
    for (int s = 1; s <= 8; s++) begin
      tick;
      if (s == 4) push(2'b01, 1, 0);
      if (s == 8) begin ack_i = 1; push(2'b01, 0, 1); end
      @(negedge clk);
      if (s != 4) chk($sformatf("wd_s%0d_timeout", s), 32'(timeout_o), 32'h0);
      if (s == 5) chk("wd_restart_stb", 32'(stb_o), 32'h1);
    end
    tick; ack_i = 0; cyc_i_0 = 0; stb_i_0 = 0;
    tick;

    // Async reset mid-transfer
    cyc_i_1 = 1; stb_i_1 = 1;
    tick;
    @(negedge clk); chk("pre_rst_gnt", 32'(gnt_o), 32'h2);
    chk("pre_rst_stb", 32'(stb_o), 32'h1);
    #2 rst = 1'b0;
    #1 ack_i = 1;
    #1 chk("async_rst_gnt", 32'(gnt_o), 32'h0);
    chk("async_rst_bus", {29'h0, cyc_o, stb_o, ack_o_1}, 32'h0);
    ack_i = 0; cyc_i_1 = 0; stb_i_1 = 0;
    @(negedge clk); rst = 1'b1;

    // First tie after reset goes to master 0, then master 1 after one gap
    tick; cyc_i_0 = 1; stb_i_0 = 1; cyc_i_1 = 1; stb_i_1 = 1;
    adr_i_0 = 32'h10; adr_i_1 = 32'h20;
    @(negedge clk); chk("tie_gap", 32'(gnt_o), 32'h0);
    tick;
    @(negedge clk); chk("tie_gnt_m0", 32'(gnt_o), 32'h1);
    chk("tie_adr_m0", adr_o, 32'h10);
    tick; cyc_i_0 = 0; stb_i_0 = 0;
    tick;
    @(negedge clk); chk("tie_idle_gap", 32'(gnt_o), 32'h0);
    tick;
    @(negedge clk); chk("tie_gnt_m1", 32'(gnt_o), 32'h2);
    chk("tie_adr_m1", adr_o, 32'h20);
    tick; cyc_i_1 = 0; stb_i_1 = 0;
    tick;
    @(negedge clk); chk("scoreboard_empty", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2to1.md
Name: wb_arbiter_2to1

Overview:
- Shares one Wishbone slave port between two Wishbone master ports, e.g. both wb_master instances of the master block contending for a single memory slave.
- Round-robin arbitration at Wishbone cycle granularity: a grant is held for a master's whole cyc window.
- Watchdog terminates stalled strobes so a dead slave cannot lock the bus.
- Sits between master-side interconnect and one slave.

Parameters:
- DATA_WIDTH, 32, width of read/write data buses.
- ADDR_WIDTH, 32, width of address bus.
- TIMEOUT_CYCLES, 64, cycles a strobe may wait for ack before the watchdog fires; legal range 2..65535.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low, synchronous deassert assumed by integration.
- cyc_i_0  in  1  master 0 bus request / cycle.
- stb_i_0  in  1  master 0 strobe.
- we_i_0  in  1  master 0 write enable.
- adr_i_0  in  ADDR_WIDTH  master 0 address.
- dat_i_0  in  DATA_WIDTH  master 0 write data.
- dat_o_0  out  DATA_WIDTH  read data to master 0.
- ack_o_0  out  1  acknowledge to master 0.
- cyc_i_1, stb_i_1, we_i_1, adr_i_1, dat_i_1, dat_o_1, ack_o_1: same set for master 1.
- cyc_o  out  1  slave cycle.
- stb_o  out  1  slave strobe.
- we_o  out  1  slave write enable.
- adr_o  out  ADDR_WIDTH  slave address.
- dat_o  out  DATA_WIDTH  slave write data.
- dat_i  in  DATA_WIDTH  slave read data.
- ack_i  in  1  slave acknowledge.
- gnt_o  out  2  one-hot registered grant; bit n = master n owns the slave.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (rst=0, async): state IDLE; gnt_o=00; last_gnt=1, so master 0 wins the first tie; watchdog count 0; timeout_o=0.
  - All slave outputs are 0 while no grant is held. ack_o_0 and ack_o_1 are 0.
- FSM states: IDLE, GNT0, GNT1 (registered).
- IDLE transitions:
  - Only cyc_i_0 high → GNT0.
  - Only cyc_i_1 high → GNT1.
  - Both high → grant the master that is not last_gnt.
  - Neither high → stay IDLE.
- Grant latency: exactly 1 cycle from cyc request seen in IDLE to gnt_o asserted.
- GNTn:
  - Slave outputs are a combinational mux of master n inputs.
  - ack_o_n = ack_i OR watchdog ack. The other master's ack_o = 0.
  - dat_o_0 and dat_o_1 both carry dat_i at all times; only ack qualifies the data.
- Release: in GNTn with cyc_i_n low → IDLE next cycle and last_gnt=n.
  - A one-cycle IDLE gap between grants is mandatory; no direct GNT0→GNT1.
- Watchdog:
  - Counts cycles in GNTn with stb_i_n=1 and ack_i=0.
  - Cleared on ack_i, on stb_i_n=0, and on entering IDLE.
  - When the count reaches TIMEOUT_CYCLES-1: one-cycle synthetic ack to master n, timeout_o=1, stb_o forced 0 that cycle, count cleared. Grant is kept.
- Simultaneous ack_i and timeout in the same cycle: ack_i wins; no timeout_o.
- cyc_i_n drop mid-transfer (no ack yet): slave cyc_o/stb_o drop combinationally that cycle; release proceeds normally.
- Reset mid-transfer: all outputs go to reset values immediately (async); no pending ack is delivered.
- A master that drops cyc while IDLE but before grant is simply not granted; requests are not latched.

Decomposition:
- Package wb_arb_pkg holds:
  - FSM state enum (IDLE, GNT0, GNT1).
  - Grant one-hot constants GNT_NONE, GNT_M0, GNT_M1.
  - Watchdog counter width derived from TIMEOUT_CYCLES.
- Sub-module wb_arb_watchdog: counter with clear/enable inputs and a fire output.
- FSM and mux stay in the top module.

Test Plan:
- Single master: m0 cyc/stb/we=1, adr=0x10, dat=0xA5A5A5A5 → gnt_o=01 next cycle; adr_o=0x10, dat_o=0xA5A5A5A5. Slave ack → ack_o_0=1, ack_o_1=0.
- Tie after reset: both cyc rise in same cycle → gnt_o=01. m0 drops cyc → 1 IDLE cycle (gnt_o=00) → gnt_o=10.
- Round-robin fairness: both request continuously, each releasing after 2 acks → grants alternate 01,00,10,00,01…; no master starved over 8 cycles.
- Read data: m1 granted, stb_i_1=1, we_i_1=0; slave dat_i=0x12345678 with ack_i=1 → dat_o_1=0x12345678, ack_o_1=1 same cycle.
- Watchdog: TIMEOUT_CYCLES=4, m0 strobes, slave never acks → ack_o_0 and timeout_o pulse on 4th strobe cycle, stb_o=0 that cycle. ack_i on exactly that cycle instead → normal ack, timeout_o=0.
- Async reset mid-transfer: assert rst=0 while GNT1 with stb_o=1 → gnt_o=00, cyc_o=stb_o=0 without waiting for clk. After release, the first tie is granted to m0.
